// File: rtl/fifo_w2n_pkg.sv
// Shared constants, width helpers and lane-order encoding for the wide-to-narrow FIFO.
// Used by fifo_wide2narrow and fifo_sdp_ram.
package fifo_w2n_pkg;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } lane_order_e;

    localparam int DEF_DIN_W = 128;
    localparam int DEF_RATIO = 8;
    localparam int DEF_DEPTH = 512;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Pointers carry one extra MSB used as the wrap flag.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int rd_cnt_w(input int depth, input int ratio);
        return clog2(depth * ratio) + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered 1-cycle read.
// A read of the address being written on the same edge returns the new data.
module fifo_sdp_ram
    import fifo_w2n_pkg::*;
#(
    parameter int DATA_W = DEF_DIN_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = clog2(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array has no reset so it maps onto block RAM; the FIFO pointers alone define valid data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_wide2narrow.sv
// Wide-write / narrow-read synchronous FIFO. Define FIFO_W2N_FWFT_EN for
// first-word-fall-through output; the default build is standard (registered read) mode.
module fifo_wide2narrow
    import fifo_w2n_pkg::*;
#(
    parameter int DIN_W        = DEF_DIN_W,
    parameter int RATIO        = DEF_RATIO,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int PROG_FULL_TH = DEPTH - 16,
    parameter int MSB_FIRST    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIN_W-1:0]            din,
    input  logic                        wr_en,
    output logic                        full,
    output logic                        prog_full,
    output logic [clog2(DEPTH):0]       wr_data_count,
    output logic                        overflow,
    input  logic                        rd_en,
    output logic [DIN_W/RATIO-1:0]      dout,
    output logic                        empty,
    output logic [clog2(DEPTH*RATIO):0] rd_data_count,
    output logic                        underflow
);

    localparam int DOUT_W = DIN_W / RATIO;
    localparam int AW     = clog2(DEPTH);
    localparam int PW     = ptr_w(DEPTH);
    localparam int LW     = clog2(RATIO);
    localparam int CW     = rd_cnt_w(DEPTH, RATIO);
    localparam lane_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_lane;
    logic              r_full;
    logic              r_prog_full;
    logic              r_empty;
    logic              r_overflow;
    logic              r_underflow;
    logic [PW-1:0]     r_wr_count;
    logic [CW-1:0]     r_rd_count;
    logic [DOUT_W-1:0] r_dout;

    logic                         w_wr_acc;
    logic                         w_int_rd;
    logic                         w_last_lane;
    logic [PW-1:0]                w_wr_ptr_nxt;
    logic [PW-1:0]                w_rd_ptr_nxt;
    logic [PW-1:0]                w_words_nxt;
    logic [LW-1:0]                w_lane_nxt;
    logic [LW-1:0]                w_slice;
    logic [CW-1:0]                w_rd_count_nxt;
    logic [DIN_W-1:0]             w_ram_q;
    logic [RATIO-1:0][DOUT_W-1:0] w_lanes;

    assign w_wr_acc    = wr_en && !r_full;
    assign w_last_lane = (r_lane == LW'(RATIO - 1));

`ifdef FIFO_W2N_FWFT_EN
    logic r_valid;
    logic w_valid_nxt;
    // The output register prefetches whenever it is empty or being consumed.
    assign w_int_rd       = (r_wr_ptr != r_rd_ptr) && (!r_valid || rd_en);
    assign w_valid_nxt    = w_int_rd || (r_valid && !rd_en);
    assign w_rd_count_nxt = {w_words_nxt, {LW{1'b0}}} - CW'(w_lane_nxt) + CW'(w_valid_nxt);
`else
    assign w_int_rd       = rd_en && !r_empty;
    assign w_rd_count_nxt = {w_words_nxt, {LW{1'b0}}} - CW'(w_lane_nxt);
`endif

    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_int_rd && w_last_lane);
    assign w_lane_nxt   = w_int_rd ? r_lane + LW'(1) : r_lane;
    assign w_words_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    assign w_slice = (ORDER == ORDER_MSB_FIRST) ? ~r_lane : r_lane;
    assign w_lanes = w_ram_q;

    // RAM is addressed with the next read pointer so its output always holds the head word.
    fifo_sdp_ram #(
        .DATA_W (DIN_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (din),
        .i_raddr (w_rd_ptr_nxt[AW-1:0]),
        .o_rdata (w_ram_q)
    );

    // NOTE: status flags are registered from next-state values so they line up with the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_lane      <= '0;
            r_full      <= 1'b0;
            r_prog_full <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_wr_count  <= '0;
            r_rd_count  <= '0;
            r_dout      <= '0;
`ifdef FIFO_W2N_FWFT_EN
            r_valid     <= 1'b0;
`endif
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_lane      <= w_lane_nxt;
            r_full      <= (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0])
                        && (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
            r_prog_full <= (w_words_nxt >= PW'(PROG_FULL_TH));
            r_overflow  <= wr_en && r_full;
            r_underflow <= rd_en && r_empty;
            r_wr_count  <= w_words_nxt;
            r_rd_count  <= w_rd_count_nxt;
            if (w_int_rd) begin
                r_dout <= w_lanes[w_slice];
            end
`ifdef FIFO_W2N_FWFT_EN
            r_valid     <= w_valid_nxt;
            r_empty     <= !w_valid_nxt;
`else
            r_empty     <= (w_rd_count_nxt == '0);
`endif
        end
    end

    assign full          = r_full;
    assign prog_full     = r_prog_full;
    assign wr_data_count = r_wr_count;
    assign overflow      = r_overflow;
    assign dout          = r_dout;
    assign empty         = r_empty;
    assign rd_data_count = r_rd_count;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_fifo_wide2narrow.sv
// Scoreboard bench for fifo_wide2narrow: an MSB-first and an LSB-first instance share stimulus.
// Expectations adapt when FIFO_W2N_FWFT_EN is defined.
module tb_fifo_wide2narrow;

    localparam int DIN_W  = 128;
    localparam int RATIO  = 8;
    localparam int DEPTH  = 512;
    localparam int DOUT_W = DIN_W / RATIO;
    localparam int PF_TH  = DEPTH - 16;
`ifdef FIFO_W2N_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif
    localparam int PRE_READS = FWFT ? 6 : 7;
    localparam int RD_START  = FWFT ? 2 : 1;

    logic              clk;
    logic              rst;
    logic [DIN_W-1:0]  din;
    logic              wr_en;
    logic              rd_en;

    logic              full_m, prog_full_m, ovf_m, empty_m, unf_m;
    logic [9:0]        wcnt_m;
    logic [12:0]       rcnt_m;
    logic [DOUT_W-1:0] dout_m;
    logic              full_l, prog_full_l, ovf_l, empty_l, unf_l;
    logic [9:0]        wcnt_l;
    logic [12:0]       rcnt_l;
    logic [DOUT_W-1:0] dout_l;

    logic [DOUT_W-1:0] q_m[$];
    logic [DOUT_W-1:0] q_l[$];
    int checks;
    int errors;

    fifo_wide2narrow #(.DIN_W(DIN_W), .RATIO(RATIO), .DEPTH(DEPTH), .PROG_FULL_TH(PF_TH), .MSB_FIRST(1)) u_dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full_m), .prog_full(prog_full_m),
        .wr_data_count(wcnt_m), .overflow(ovf_m), .rd_en(rd_en), .dout(dout_m), .empty(empty_m),
        .rd_data_count(rcnt_m), .underflow(unf_m)
    );

    fifo_wide2narrow #(.DIN_W(DIN_W), .RATIO(RATIO), .DEPTH(DEPTH), .PROG_FULL_TH(PF_TH), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full_l), .prog_full(prog_full_l),
        .wr_data_count(wcnt_l), .overflow(ovf_l), .rd_en(rd_en), .dout(dout_l), .empty(empty_l),
        .rd_data_count(rcnt_l), .underflow(unf_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [DIN_W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_word(input logic [DIN_W-1:0] d);
        for (int k = 0; k < RATIO; k++) begin
            q_m.push_back(d[DIN_W-1-k*DOUT_W -: DOUT_W]);
            q_l.push_back(d[k*DOUT_W +: DOUT_W]);
        end
    endtask

    task automatic pop_exp(output bit have, output logic [DOUT_W-1:0] em, output logic [DOUT_W-1:0] el);
        have = (q_m.size() > 0) && (q_l.size() > 0);
        em = '0;
        el = '0;
        if (have) begin
            em = q_m.pop_front();
            el = q_l.pop_front();
        end
    endtask

    // One clock: drive inputs, push accepted writes, return read acceptance and observed read data.
    task automatic cycle(input logic we, input logic re, input logic [DIN_W-1:0] d,
                         output logic rd_ok, output logic [DOUT_W-1:0] gm, output logic [DOUT_W-1:0] gl);
        wr_en = we;
        rd_en = re;
        din   = d;
        rd_ok = re && !empty_m;
        gm = dout_m;
        gl = dout_l;
        if (we && !full_m && !rst) push_word(d);
        @(posedge clk);
        #1;
        if (!FWFT) begin
            gm = dout_m;
            gl = dout_l;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        logic ok;
        logic [DOUT_W-1:0] gm, gl;
        rst = 1'b1;
        cycle(1'b0, 1'b0, '0, ok, gm, gl);
        rst = 1'b0;
        q_m.delete();
        q_l.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty_m !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty_m); end
        checks++; if (full_m !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full_m); end
        checks++; if (prog_full_m !== 1'b0) begin errors++; $display("FAIL reset_prog_full got %b exp 0", prog_full_m); end
        checks++; if (wcnt_m !== 10'd0) begin errors++; $display("FAIL reset_wcnt got %0d exp 0", wcnt_m); end
        checks++; if (rcnt_m !== 13'd0) begin errors++; $display("FAIL reset_rcnt got %0d exp 0", rcnt_m); end
        checks++; if (ovf_m !== 1'b0 || unf_m !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", ovf_m, unf_m); end
        checks++; if (dout_m !== 16'h0 || dout_l !== 16'h0) begin errors++; $display("FAIL reset_dout got %h/%h exp 0", dout_m, dout_l); end
        checks++;
        if ({empty_l, full_l, prog_full_l, ovf_l, unf_l} !== 5'b10000 || wcnt_l !== 10'd0 || rcnt_l !== 13'd0) begin
            errors++; $display("FAIL reset_lsb_inst flags %b%b%b%b%b counts %0d/%0d exp 10000 0/0",
                               empty_l, full_l, prog_full_l, ovf_l, unf_l, wcnt_l, rcnt_l);
        end
    endtask

    task automatic test_underflow();
        logic ok;
        logic [DOUT_W-1:0] gm, gl;
        cycle(1'b0, 1'b1, '0, ok, gm, gl);
        checks++; if (unf_m !== 1'b1) begin errors++; $display("FAIL underflow_pulse got %b exp 1", unf_m); end
        checks++; if (dout_m !== 16'h0) begin errors++; $display("FAIL underflow_dout got %h exp 0", dout_m); end
        cycle(1'b0, 1'b0, '0, ok, gm, gl);
        checks++; if (unf_m !== 1'b0) begin errors++; $display("FAIL underflow_one_cycle got %b exp 0", unf_m); end
    endtask

    task automatic test_first_word();
        logic ok;
        bit have;
        logic [DOUT_W-1:0] gm, gl, em, el;
        do_reset();
        cycle(1'b1, 1'b0, rand_word(), ok, gm, gl);
        checks++; if (empty_m !== (FWFT ? 1'b1 : 1'b0)) begin errors++; $display("FAIL first_empty_edge1 got %b exp %b", empty_m, FWFT); end
        checks++; if (wcnt_m !== 10'd1) begin errors++; $display("FAIL first_wcnt got %0d exp 1", wcnt_m); end
        cycle(1'b0, 1'b0, '0, ok, gm, gl);
        checks++; if (empty_m !== 1'b0) begin errors++; $display("FAIL first_empty_edge2 got %b exp 0", empty_m); end
        checks++; if (rcnt_m !== 13'd8) begin errors++; $display("FAIL first_rcnt got %0d exp 8", rcnt_m); end
        checks++;
        if (dout_m !== (FWFT ? q_m[0] : 16'h0)) begin
            errors++; $display("FAIL first_dout_idle got %h exp %h", dout_m, FWFT ? q_m[0] : 16'h0);
        end
        for (int i = 0; i < RATIO; i++) begin
            cycle(1'b0, 1'b1, '0, ok, gm, gl);
            pop_exp(have, em, el);
            checks++;
            if (!ok || !have || gm !== em || gl !== el) begin
                errors++; $display("FAIL first_data lane %0d got %h/%h exp %h/%h acc=%b", i, gm, gl, em, el, ok);
            end
        end
        checks++; if (empty_m !== 1'b1) begin errors++; $display("FAIL first_drained got %b exp 1", empty_m); end
    endtask

    task automatic test_stream();
        logic ok;
        bit have;
        logic [DOUT_W-1:0] gm, gl, em, el;
        do_reset();
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, rand_word(), ok, gm, gl);
        checks++; if (wcnt_m !== 10'd256) begin errors++; $display("FAIL stream_wcnt got %0d exp 256", wcnt_m); end
        checks++; if (rcnt_m !== 13'd2048) begin errors++; $display("FAIL stream_rcnt got %0d exp 2048", rcnt_m); end
        checks++; if (prog_full_m !== 1'b0 || full_m !== 1'b0) begin errors++; $display("FAIL stream_flags got %b%b exp 00", prog_full_m, full_m); end
        for (int i = 0; i < 2048; i++) begin
            cycle(1'b0, 1'b1, '0, ok, gm, gl);
            pop_exp(have, em, el);
            checks++;
            if (!ok || !have || gm !== em || gl !== el) begin
                errors++; $display("FAIL stream_data idx %0d got %h/%h exp %h/%h acc=%b", i, gm, gl, em, el, ok);
            end
        end
        checks++; if (rcnt_m !== 13'd0 || rcnt_l !== 13'd0) begin errors++; $display("FAIL stream_end_rcnt got %0d/%0d exp 0", rcnt_m, rcnt_l); end
        checks++; if (empty_m !== 1'b1 || empty_l !== 1'b1) begin errors++; $display("FAIL stream_end_empty got %b/%b exp 1", empty_m, empty_l); end
        cycle(1'b0, 1'b1, '0, ok, gm, gl);
        checks++; if (unf_m !== 1'b1 || unf_l !== 1'b1) begin errors++; $display("FAIL stream_underflow got %b/%b exp 1", unf_m, unf_l); end
        checks++; if (dout_m !== em || dout_l !== el) begin errors++; $display("FAIL stream_dout_hold got %h/%h exp %h/%h", dout_m, dout_l, em, el); end
    endtask

    task automatic test_full();
        logic ok;
        bit have;
        logic [DOUT_W-1:0] gm, gl, em, el;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, rand_word(), ok, gm, gl);
            checks++;
            if (prog_full_m !== ((i + 1) >= PF_TH) || full_m !== (i == DEPTH - 1)) begin
                errors++; $display("FAIL fill_flags count %0d got pf=%b full=%b exp pf=%b full=%b",
                                   i + 1, prog_full_m, full_m, (i + 1) >= PF_TH, i == DEPTH - 1);
            end
        end
        checks++; if (wcnt_m !== 10'd512) begin errors++; $display("FAIL full_wcnt got %0d exp 512", wcnt_m); end
        cycle(1'b1, 1'b0, rand_word(), ok, gm, gl);
        checks++; if (ovf_m !== 1'b1 || ovf_l !== 1'b1) begin errors++; $display("FAIL overflow_pulse got %b/%b exp 1", ovf_m, ovf_l); end
        checks++; if (wcnt_m !== 10'd512 || full_m !== 1'b1) begin errors++; $display("FAIL overflow_hold got %0d full=%b exp 512 1", wcnt_m, full_m); end
        cycle(1'b0, 1'b0, '0, ok, gm, gl);
        checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle got %b exp 0", ovf_m); end

        for (int i = 0; i < PRE_READS; i++) begin
            cycle(1'b0, 1'b1, '0, ok, gm, gl);
            pop_exp(have, em, el);
            checks++;
            if (!ok || !have || gm !== em || gl !== el) begin
                errors++; $display("FAIL release_data idx %0d got %h/%h exp %h/%h", i, gm, gl, em, el);
            end
        end
        cycle(1'b1, 1'b1, rand_word(), ok, gm, gl);
        pop_exp(have, em, el);
        checks++; if (!have || gm !== em || gl !== el) begin errors++; $display("FAIL release_last got %h/%h exp %h/%h", gm, gl, em, el); end
        checks++; if (ovf_m !== 1'b1) begin errors++; $display("FAIL release_reject got %b exp 1", ovf_m); end
        checks++; if (full_m !== 1'b0 || wcnt_m !== 10'd511) begin errors++; $display("FAIL release_drop got full=%b cnt=%0d exp 0 511", full_m, wcnt_m); end
        cycle(1'b1, 1'b0, rand_word(), ok, gm, gl);
        checks++; if (ovf_m !== 1'b0 || full_m !== 1'b1 || wcnt_m !== 10'd512) begin
            errors++; $display("FAIL release_refill got ovf=%b full=%b cnt=%0d exp 0 1 512", ovf_m, full_m, wcnt_m);
        end
        for (int n = 0; n < 5000 && q_m.size() > 0; n++) begin
            cycle(1'b0, 1'b1, '0, ok, gm, gl);
            pop_exp(have, em, el);
            checks++;
            if (!ok || !have || gm !== em || gl !== el) begin
                errors++; $display("FAIL full_drain idx %0d got %h/%h exp %h/%h", n, gm, gl, em, el);
            end
        end
        checks++; if (q_m.size() != 0 || empty_m !== 1'b1) begin errors++; $display("FAIL full_drain_end left %0d empty=%b exp 0 1", q_m.size(), empty_m); end
    endtask

    task automatic test_wrap();
        localparam int NW = 1600;
        logic ok;
        bit have;
        logic we, re;
        logic [DOUT_W-1:0] gm, gl, em, el;
        do_reset();
        for (int i = 0; i < NW * RATIO + RD_START; i++) begin
            we = ((i % RATIO) == 0) && ((i / RATIO) < NW);
            re = (i >= RD_START);
            cycle(we, re, rand_word(), ok, gm, gl);
            if (re) begin
                pop_exp(have, em, el);
                checks++;
                if (!ok || !have || gm !== em || gl !== el) begin
                    errors++; $display("FAIL wrap_data cyc %0d got %h/%h exp %h/%h acc=%b", i, gm, gl, em, el, ok);
                end
            end
            checks++;
            if (full_m !== 1'b0 || unf_m !== 1'b0) begin
                errors++; $display("FAIL wrap_flags cyc %0d got full=%b unf=%b exp 0 0", i, full_m, unf_m);
            end
        end
        checks++; if (empty_m !== 1'b1 || rcnt_m !== 13'd0) begin errors++; $display("FAIL wrap_end got empty=%b rcnt=%0d exp 1 0", empty_m, rcnt_m); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        bit have;
        logic [DOUT_W-1:0] gm, gl, em, el;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'(i % 2), rand_word(), ok, gm, gl);
            if (ok) begin
                pop_exp(have, em, el);
                checks++;
                if (!have || gm !== em || gl !== el) begin
                    errors++; $display("FAIL midrst_data cyc %0d got %h/%h exp %h/%h", i, gm, gl, em, el);
                end
            end
        end
        rst = 1'b1;
        cycle(1'b1, 1'b1, rand_word(), ok, gm, gl);
        rst = 1'b0;
        q_m.delete();
        q_l.delete();
        checks++; if (empty_m !== 1'b1 || full_m !== 1'b0 || prog_full_m !== 1'b0) begin
            errors++; $display("FAIL midrst_flags got e=%b f=%b pf=%b exp 1 0 0", empty_m, full_m, prog_full_m);
        end
        checks++; if (wcnt_m !== 10'd0 || rcnt_m !== 13'd0) begin errors++; $display("FAIL midrst_counts got %0d/%0d exp 0/0", wcnt_m, rcnt_m); end
        checks++; if (dout_m !== 16'h0) begin errors++; $display("FAIL midrst_dout got %h exp 0", dout_m); end
        cycle(1'b1, 1'b0, rand_word(), ok, gm, gl);
        cycle(1'b0, 1'b0, '0, ok, gm, gl);
        for (int i = 0; i < RATIO; i++) begin
            cycle(1'b0, 1'b1, '0, ok, gm, gl);
            pop_exp(have, em, el);
            checks++;
            if (!ok || !have || gm !== em || gl !== el) begin
                errors++; $display("FAIL midrst_after lane %0d got %h/%h exp %h/%h", i, gm, gl, em, el);
            end
        end
        checks++; if (empty_m !== 1'b1 || wcnt_m !== 10'd0) begin errors++; $display("FAIL midrst_end got e=%b cnt=%0d exp 1 0", empty_m, wcnt_m); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;
        test_reset();
        test_underflow();
        test_first_word();
        test_stream();
        test_full();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
